// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between two
//               requesters (A and B) with req/ack handshakes. Each granted
//               transaction runs IDLE -> ACCESS -> DONE: the RAM address,
//               operation and write data are latched, select is pulsed for
//               exactly one cycle, then the requester is acked. Out-of-range
//               addresses skip the RAM and are acked with err set.
// Ports       : clk, rst                    clock / synchronous active-high reset
//               a_req/op/addr/wdata         requester A request inputs
//               a_ack/err/rdata             requester A completion outputs
//               b_*                         same set for requester B
//               ram_address/select/         RAM control outputs (all registered)
//               operation/wdata
//               ram_rdata                   RAM read data (valid while select=1)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter  int word_size   = 20,
   parameter  int word_amount = 30,
   localparam int addr_w      = $clog2(word_amount)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic                 a_op,
   input  logic [addr_w-1:0]    a_addr,
   input  logic [word_size-1:0] a_wdata,
   output logic                 a_ack,
   output logic                 a_err,
   output logic [word_size-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_op,
   input  logic [addr_w-1:0]    b_addr,
   input  logic [word_size-1:0] b_wdata,
   output logic                 b_ack,
   output logic                 b_err,
   output logic [word_size-1:0] b_rdata,
   output logic [addr_w-1:0]    ram_address,
   output logic                 ram_select,
   output logic                 ram_operation,
   output logic [word_size-1:0] ram_wdata,
   input  logic [word_size-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // One extra bit so the comparison also works when word_amount is a power of two.
   localparam logic [addr_w:0] amount_c = (addr_w + 1)'(word_amount);

   state_t                state, state_next;
   logic                  last_grant, last_grant_next;   // 0 = A, 1 = B
   logic                  grant, grant_next;             // 0 = A, 1 = B
   logic [addr_w-1:0]     ram_address_next;
   logic                  ram_select_next;
   logic                  ram_operation_next;
   logic [word_size-1:0]  ram_wdata_next;
   logic                  a_ack_next, a_err_next, b_ack_next, b_err_next;
   logic [word_size-1:0]  a_rdata_next, b_rdata_next;

   // Requester selection: B wins when it is alone, or when both ask and A
   // was the previous grantee.
   logic                  pick_b;
   logic [addr_w-1:0]     pick_addr;
   logic                  pick_in_range;

   assign pick_b        = b_req & (~a_req | ~last_grant);
   assign pick_addr     = pick_b ? b_addr : a_addr;
   assign pick_in_range = ({1'b0, pick_addr} < amount_c);

   always_comb begin
      state_next         = state;
      last_grant_next    = last_grant;
      grant_next         = grant;
      ram_address_next   = ram_address;
      ram_select_next    = 1'b0;
      ram_operation_next = ram_operation;
      ram_wdata_next     = ram_wdata;
      a_ack_next         = 1'b0;
      a_err_next         = 1'b0;
      b_ack_next         = 1'b0;
      b_err_next         = 1'b0;
      a_rdata_next       = a_rdata;
      b_rdata_next       = b_rdata;

      case (state)
         IDLE: begin
            if (a_req || b_req) begin
               grant_next         = pick_b;
               ram_address_next   = pick_addr;
               ram_operation_next = pick_b ? b_op    : a_op;
               ram_wdata_next     = pick_b ? b_wdata : a_wdata;
               if (pick_in_range) begin
                  ram_select_next = 1'b1;
                  state_next      = ACCESS;
               end else begin
                  // Skip the RAM entirely; the ack registered here is seen in DONE.
                  state_next = DONE;
                  if (pick_b) begin
                     b_ack_next   = 1'b1;
                     b_err_next   = 1'b1;
                     b_rdata_next = '0;
                  end else begin
                     a_ack_next   = 1'b1;
                     a_err_next   = 1'b1;
                     a_rdata_next = '0;
                  end
               end
            end
         end

         ACCESS: begin
            // Ack is registered on this edge so it is visible during DONE.
            state_next = DONE;
            if (grant) begin
               b_ack_next   = 1'b1;
               b_rdata_next = ram_operation ? '0 : ram_rdata;
            end else begin
               a_ack_next   = 1'b1;
               a_rdata_next = ram_operation ? '0 : ram_rdata;
            end
         end

         DONE: begin
            last_grant_next = grant;
            state_next      = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         grant         <= 1'b0;
         ram_address   <= '0;
         ram_select    <= 1'b0;
         ram_operation <= 1'b0;
         ram_wdata     <= '0;
         a_ack         <= 1'b0;
         a_err         <= 1'b0;
         a_rdata       <= '0;
         b_ack         <= 1'b0;
         b_err         <= 1'b0;
         b_rdata       <= '0;
      end else begin
         state         <= state_next;
         last_grant    <= last_grant_next;
         grant         <= grant_next;
         ram_address   <= ram_address_next;
         ram_select    <= ram_select_next;
         ram_operation <= ram_operation_next;
         ram_wdata     <= ram_wdata_next;
         a_ack         <= a_ack_next;
         a_err         <= a_err_next;
         a_rdata       <= a_rdata_next;
         b_ack         <= b_ack_next;
         b_err         <= b_err_next;
         b_rdata       <= b_rdata_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. A behavioural RAM sits on
//               the RAM port; expected completions are queued when a request
//               is driven and compared whenever an ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int WS = 20;
   localparam int WA = 30;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [WS-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ack, a_err, b_ack, b_err;
   logic [WS-1:0] a_rdata, b_rdata;
   logic [AW-1:0] ram_address;
   logic          ram_select, ram_operation;
   logic [WS-1:0] ram_wdata, ram_rdata;

   ram_arbiter #(.word_size(WS), .word_amount(WA)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .ram_address(ram_address), .ram_select(ram_select),
      .ram_operation(ram_operation), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM
   logic [WS-1:0] mem [WA] = '{default: '0};
   assign ram_rdata = (ram_select && !ram_operation && ram_address < AW'(WA))
                      ? mem[ram_address] : '0;
   always @(posedge clk)
      if (ram_select && ram_operation && ram_address < AW'(WA))
         mem[ram_address] <= ram_wdata;

   // Reference contents and scoreboard
   logic [WS-1:0] shadow [WA] = '{default: '0};
   typedef struct {
      bit            who;   // 0 = A, 1 = B
      logic          err;
      logic [WS-1:0] rdata;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   bit   prev_sel = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Ack monitor: every ack must match the head of the scoreboard
   always @(negedge clk) begin
      if (a_ack || b_ack) begin
         check("dual_ack", 32'(a_ack & b_ack), 32'd0);
         if (exp_q.size() == 0) begin
            check("ack_expected", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_who", 32'(b_ack), 32'(mon_e.who));
            check("ack_err", 32'(b_ack ? b_err : a_err), 32'(mon_e.err));
            check("ack_rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(mon_e.rdata));
            check("other_err", 32'(b_ack ? a_err : b_err), 32'd0);
         end
      end
      if (ram_select) check("select_twice", 32'(prev_sel), 32'd0);
      prev_sel = ram_select;
   end

   task automatic push_exp(input bit who, input bit op, input logic [AW-1:0] addr,
                           input logic [WS-1:0] wd);
      exp_t e;
      bit   in_range;
      in_range = (addr < AW'(WA));
      e.who    = who;
      e.err    = !in_range;
      e.rdata  = (!op && in_range) ? shadow[addr] : '0;
      if (op && in_range) shadow[addr] = wd;
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input bit who, input bit req, input bit op,
                            input logic [AW-1:0] addr, input logic [WS-1:0] wd);
      if (who) begin
         b_req = req; b_op = op; b_addr = addr; b_wdata = wd;
      end else begin
         a_req = req; a_op = op; a_addr = addr; a_wdata = wd;
      end
   endtask

   // One complete transaction from an idle arbiter; checks strobe and latency.
   task automatic do_txn(input bit who, input bit op, input logic [AW-1:0] addr,
                         input logic [WS-1:0] wd);
      int sel_cycles = 0;
      int ack_at     = 0;
      bit in_range;
      in_range = (addr < AW'(WA));
      push_exp(who, op, addr, wd);
      drive_req(who, 1'b1, op, addr, wd);
      for (int i = 1; i <= 8 && ack_at == 0; i++) begin
         @(negedge clk);
         if (ram_select) begin
            sel_cycles++;
            check("sel_addr", 32'(ram_address), 32'(addr));
            check("sel_op", 32'(ram_operation), 32'(op));
            if (op) check("sel_wdata", 32'(ram_wdata), 32'(wd));
         end
         if (who ? b_ack : a_ack) ack_at = i;
      end
      check("ack_latency", 32'(ack_at), in_range ? 32'd2 : 32'd1);
      check("sel_cycles", 32'(sel_cycles), in_range ? 32'd1 : 32'd0);
      drive_req(who, 1'b0, op, addr, wd);
      @(negedge clk);
   endtask

   initial begin
      int na, nb;

      // 1: reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_a_ack", 32'(a_ack), 32'd0);
      check("rst_a_err", 32'(a_err), 32'd0);
      check("rst_a_rdata", 32'(a_rdata), 32'd0);
      check("rst_b_ack", 32'(b_ack), 32'd0);
      check("rst_b_err", 32'(b_err), 32'd0);
      check("rst_b_rdata", 32'(b_rdata), 32'd0);
      check("rst_select", 32'(ram_select), 32'd0);
      check("rst_address", 32'(ram_address), 32'd0);
      check("rst_operation", 32'(ram_operation), 32'd0);
      check("rst_wdata", 32'(ram_wdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 2, 3: A write then read back
      do_txn(1'b0, 1'b1, AW'(2), WS'(17));
      do_txn(1'b0, 1'b0, AW'(2), '0);
      // Boundary address and all-ones data; lone B requester back to back
      do_txn(1'b0, 1'b1, AW'(29), 20'hFFFFF);
      do_txn(1'b0, 1'b0, AW'(29), '0);
      do_txn(1'b1, 1'b1, AW'(0), WS'(3));
      do_txn(1'b1, 1'b0, AW'(0), '0);

      // 4: both requesting continuously right after reset -> A,B,A,B
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      push_exp(1'b0, 1'b1, AW'(5), WS'(5));
      push_exp(1'b1, 1'b1, AW'(6), WS'(6));
      push_exp(1'b0, 1'b1, AW'(5), WS'(5));
      push_exp(1'b1, 1'b1, AW'(6), WS'(6));
      drive_req(1'b0, 1'b1, 1'b1, AW'(5), WS'(5));
      drive_req(1'b1, 1'b1, 1'b1, AW'(6), WS'(6));
      na = 0;
      nb = 0;
      for (int i = 0; i < 30 && (na < 2 || nb < 2); i++) begin
         @(negedge clk);
         if (a_ack) begin na++; if (na == 2) a_req = 1'b0; end
         if (b_ack) begin nb++; if (nb == 2) b_req = 1'b0; end
      end
      check("conc_a_acks", 32'(na), 32'd2);
      check("conc_b_acks", 32'(nb), 32'd2);
      a_req = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      do_txn(1'b0, 1'b0, AW'(5), '0);
      do_txn(1'b1, 1'b0, AW'(6), '0);
      repeat (2) @(negedge clk);
      check("b_rdata_hold", 32'(b_rdata), 32'd6);

      // 5: out-of-range read from B
      do_txn(1'b1, 1'b0, AW'(30), '0);

      // 6: reset while select is high drops the transaction
      drive_req(1'b0, 1'b1, 1'b1, AW'(7), WS'(99));
      for (int i = 0; i < 4 && !ram_select; i++) @(negedge clk);
      check("mid_sel_seen", 32'(ram_select), 32'd1);
      rst = 1'b1;
      a_req = 1'b0;
      @(negedge clk);
      check("mid_rst_sel", 32'(ram_select), 32'd0);
      check("mid_rst_ack", 32'(a_ack), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_no_ack", 32'(a_ack | b_ack), 32'd0);
      do_txn(1'b0, 1'b0, AW'(2), '0);

      repeat (2) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
